// File: rtl/screen_ram_paged.sv
// screen_ram_paged: multi-page character RAM with tear-free page switch and a page clear engine
module screen_ram_paged #(
  parameter int COLS = 160,
  parameter int ROWS = 120,
  parameter int CHAR_W = 8,
  parameter int PAGES = 2,
  parameter logic [CHAR_W-1:0] BLANK = 8'h20,
  parameter int X_W = $clog2(COLS),
  parameter int Y_W = $clog2(ROWS),
  parameter int P_W = $clog2(PAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [X_W-1:0]    scrX,
  input  logic [Y_W-1:0]    scrY,
  input  logic [P_W-1:0]    selector,
  output logic [CHAR_W-1:0] caracter,
  output logic              rd_valid,
  output logic [P_W-1:0]    cur_page,
  input  logic              wr_en,
  input  logic [P_W-1:0]    wr_page,
  input  logic [X_W-1:0]    wr_x,
  input  logic [Y_W-1:0]    wr_y,
  input  logic [CHAR_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  input  logic [P_W-1:0]    clr_page,
  output logic              clr_busy,
  output logic              clr_done
);
  localparam int N = COLS * ROWS;
  localparam int A_W = $clog2(PAGES * N);
  localparam int C_W = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2;
  logic [CHAR_W-1:0] mem [PAGES*N];
  logic [1:0] state;
  logic [C_W-1:0] ptr;
  logic [P_W-1:0] cpg, rpage;
  logic top, rd_in, wr_in, we;
  logic [A_W-1:0] ra, wa;
  logic [CHAR_W-1:0] wd;
  function automatic logic [A_W-1:0] addr(input logic [P_W-1:0] p, input logic [Y_W-1:0] y,
                                          input logic [X_W-1:0] x);
    return A_W'(p) * A_W'(N) + A_W'(y) * A_W'(COLS) + A_W'(x);
  endfunction
  always_comb begin
    top = scrX == '0 && scrY == '0;
    rpage = top ? selector : cur_page;
    rd_in = 32'(scrX) < COLS && 32'(scrY) < ROWS;
    wr_in = 32'(wr_x) < COLS && 32'(wr_y) < ROWS;
    clr_busy = state == CLEAR;
    clr_done = state == DONE;
    wr_ready = state == IDLE;
    we = clr_busy || (wr_en && wr_ready && wr_in);
    wa = clr_busy ? A_W'(cpg) * A_W'(N) + A_W'(ptr) : addr(wr_page, wr_y, wr_x);
    wd = clr_busy ? BLANK : wr_data;
    ra = addr(rpage, scrY, scrX);
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // the frame-start read already uses the newly selected page
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      caracter <= '0;
      rd_valid <= 1'b0;
      cur_page <= '0;
    end else begin
      caracter <= rd_in ? mem[ra] : BLANK;
      rd_valid <= rd_in;
      if (top) cur_page <= selector;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cpg <= '0;
    end else if (state == IDLE && clr_req) begin
      state <= CLEAR;
      ptr <= '0;
      cpg <= clr_page;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == C_W'(N - 1)) state <= DONE;
    end else if (state == DONE) state <= IDLE;
endmodule

// File: tb/tb_screen_ram_paged.sv
// tb_screen_ram_paged: table vectors, random traffic vs. array model, and clear/reset sequences
module tb_screen_ram_paged;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] scrX, wr_x, wr_data, caracter;
  logic [6:0] scrY, wr_y;
  logic selector, wr_en, wr_page, clr_req, clr_page;
  logic rd_valid, cur_page, wr_ready, clr_busy, clr_done;
  int checks = 0, errors = 0;
  logic [7:0] m [2][120][160];
  bit k [2][120][160];
  int mpg, mcp, mcnt;
  bit mbusy, mdone, e_val, e_kn;
  logic [7:0] e_chr;
  typedef struct { int sx, sy, sel, we, wp, wx, wy, wd, ec, cc, ev, ep; } vec_t;
  vec_t tv[14];
  int nb, nbusy, ndone;

  screen_ram_paged dut (.clk(clk), .rst_n(rst_n), .scrX(scrX), .scrY(scrY), .selector(selector),
    .caracter(caracter), .rd_valid(rd_valid), .cur_page(cur_page), .wr_en(wr_en), .wr_page(wr_page),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready), .clr_req(clr_req),
    .clr_page(clr_page), .clr_busy(clr_busy), .clr_done(clr_done));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_rst();
    mpg = 0; mbusy = 0; mdone = 0; e_val = 0; e_chr = 8'h00; e_kn = 1;
  endtask

  task automatic model_edge();
    int rp;
    bit inr;
    inr = scrX < 160 && scrY < 120;
    rp = (scrX == 0 && scrY == 0) ? int'(selector) : mpg;
    e_val = inr;
    if (inr) begin e_chr = m[rp][scrY][scrX]; e_kn = k[rp][scrY][scrX]; end
    else begin e_chr = 8'h20; e_kn = 1; end
    if (wr_en && !mbusy && !mdone && wr_x < 160 && wr_y < 120) begin
      m[wr_page][wr_y][wr_x] = wr_data;
      k[wr_page][wr_y][wr_x] = 1;
    end
    if (mbusy) begin
      m[mcp][mcnt / 160][mcnt % 160] = 8'h20;
      k[mcp][mcnt / 160][mcnt % 160] = 1;
      mcnt++;
      if (mcnt == 19200) begin mbusy = 0; mdone = 1; end
    end else if (mdone) mdone = 0;
    else if (clr_req) begin mbusy = 1; mcnt = 0; mcp = int'(clr_page); end
    if (scrX == 0 && scrY == 0) mpg = int'(selector);
  endtask

  task automatic compare();
    chk("rd_valid", 32'(rd_valid), 32'(e_val));
    if (e_kn) chk("caracter", 32'(caracter), 32'(e_chr));
    chk("cur_page", 32'(cur_page), 32'(mpg));
    chk("wr_ready", 32'(wr_ready), 32'(!mbusy && !mdone));
    chk("clr_busy", 32'(clr_busy), 32'(mbusy));
    chk("clr_done", 32'(clr_done), 32'(mdone));
  endtask

  task automatic step();
    if (rst_n) model_edge(); else model_rst();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic rd(input int x, input int y, input int sel);
    scrX = 8'(x); scrY = 7'(y); selector = 1'(sel);
    step();
  endtask

  task automatic wr(input int p, input int x, input int y, input int d);
    wr_en = 1; wr_page = 1'(p); wr_x = 8'(x); wr_y = 7'(y); wr_data = 8'(d);
    step();
    wr_en = 0;
  endtask

  initial begin
    rst_n = 0; scrX = 0; scrY = 0; selector = 0; wr_en = 0; wr_page = 0; wr_x = 0; wr_y = 0;
    wr_data = 0; clr_req = 0; clr_page = 0;
    model_rst();
    #1;
    compare();
    step();
    step();
    rst_n = 1;

    tv[0]  = '{10, 10, 0, 1, 0, 5, 3, 'h41, 0, 0, 1, 0};
    tv[1]  = '{5, 3, 0, 0, 0, 0, 0, 0, 'h41, 1, 1, 0};
    tv[2]  = '{160, 0, 0, 0, 0, 0, 0, 0, 'h20, 1, 0, 0};
    tv[3]  = '{0, 120, 0, 0, 0, 0, 0, 0, 'h20, 1, 0, 0};
    tv[4]  = '{10, 10, 0, 1, 1, 0, 0, 'h7A, 0, 0, 1, 0};
    tv[5]  = '{10, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[6]  = '{20, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[7]  = '{0, 0, 1, 0, 0, 0, 0, 0, 'h7A, 1, 1, 1};
    tv[8]  = '{5, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tv[9]  = '{5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[11] = '{5, 3, 0, 0, 0, 0, 0, 0, 'h41, 1, 1, 0};
    tv[12] = '{5, 3, 0, 1, 0, 5, 3, 'h42, 'h41, 1, 1, 0};
    tv[13] = '{5, 3, 0, 0, 0, 0, 0, 0, 'h42, 1, 1, 0};
    for (int i = 0; i < 14; i++) begin
      scrX = 8'(tv[i].sx); scrY = 7'(tv[i].sy); selector = 1'(tv[i].sel);
      wr_en = 1'(tv[i].we); wr_page = 1'(tv[i].wp); wr_x = 8'(tv[i].wx); wr_y = 7'(tv[i].wy);
      wr_data = 8'(tv[i].wd);
      step();
      chk($sformatf("tv%0d_valid", i), 32'(rd_valid), 32'(tv[i].ev));
      chk($sformatf("tv%0d_page", i), 32'(cur_page), 32'(tv[i].ep));
      if (tv[i].cc != 0) chk($sformatf("tv%0d_char", i), 32'(caracter), 32'(tv[i].ec));
    end
    wr_en = 0;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin scrX = 0; scrY = 0; end
      else begin
        scrX = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) :
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 159)) : 8'($urandom_range(0, 7));
        scrY = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) :
               ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 119)) : 7'($urandom_range(0, 3));
      end
      selector = 1'($urandom);
      wr_en = 1'($urandom);
      wr_page = 1'($urandom);
      wr_x = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 7));
      wr_y = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 0;

    wr(1, 0, 0, 'h7A);
    rd(10, 10, 0);
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 19400; i++) begin
      clr_req = (i == 0 || i == 60);
      clr_page = 0;
      wr_en = (i == 50); wr_page = 1; wr_x = 0; wr_y = 0; wr_data = 8'h99;
      step();
      if (i == 50) chk("wr_ready_clear", 32'(wr_ready), 32'(0));
      if (clr_busy) nbusy++;
      if (clr_done) ndone++;
    end
    clr_req = 0; wr_en = 0;
    chk("clr_busy_cycles", 32'(nbusy), 32'd19200);
    chk("clr_done_pulses", 32'(ndone), 32'd1);
    nb = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        rd(x, y, 0);
        if (caracter === 8'h20) nb++;
      end
    chk("page0_blank", 32'(nb), 32'd19200);
    rd(0, 0, 1);
    chk("page1_kept", 32'(caracter), 32'h7A);

    wr(0, 50, 0, 'h11);
    wr(0, 150, 0, 'h22);
    rd(0, 0, 0);
    rd(10, 10, 0);
    clr_req = 1; clr_page = 0;
    step();
    clr_req = 0;
    repeat (100) step();
    rst_n = 0;
    #1;
    model_rst();
    compare();
    chk("rst_busy", 32'(clr_busy), 32'(0));
    step();
    step();
    rst_n = 1;
    chk("rst_ready", 32'(wr_ready), 32'(1));
    rd(50, 0, 0);
    chk("partial_cleared", 32'(caracter), 32'h20);
    rd(150, 0, 0);
    chk("partial_kept", 32'(caracter), 32'h22);
    rd(99, 0, 0);
    rd(100, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
